pattern_serializer: RTL

PATTERN_SERIALIZER -- requirements
Module: pattern_serializer

---
 rtl/pattern_serializer_pkg.sv | 26 ++
 rtl/pattern_serializer_btn_debounce.sv | 67 ++++++
 rtl/pattern_serializer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pattern_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pattern_serializer_pkg
// Purpose  : Shared types and helpers for the pattern serializer slice.
//            Holds the FSM state encoding used by the project's state
//            machines and a counter-width helper.
// Ports    : (package, no ports)
// Revision : 1.0 - initial release
// ============================================================================
package pattern_serializer_pkg;

  // Sequencer states shared by the project's state-machine blocks.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ser_state_t;

  // Width of a counter that must hold values 0..n-1; never below one bit so
  // that a modulus of 1 still yields a legal vector.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_serializer_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : Two-flop synchronizer plus level debouncer for a raw pushbutton.
//            Emits a one-cycle start_pulse on each debounced 0->1 edge.
// Ports    : clk         - clock
//            rst         - asynchronous active-high reset
//            i_ena       - enable; low freezes the debounce counter and level
//            i_btn       - raw asynchronous button input
//            start_pulse - registered one-cycle rising-edge strobe
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce
  import pattern_serializer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_ena,
  input  logic i_btn,
  output logic start_pulse
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_pulse;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
      r_cnt   <= '0;
    end else begin
      // Synchronizer always tracks the pin; only the filter obeys i_ena.
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      // With i_ena low the pulse is held so a pending start is not lost.
      if (i_ena) begin
        r_pulse <= 1'b0;
        if (r_sync2 != r_level) begin
          if (r_cnt == C_CNT_LAST) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
            r_pulse <= r_sync2;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end else begin
          // Any sample agreeing with the accepted level restarts the count.
          r_cnt <= '0;
        end
      end
    end
  end

  assign start_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/pattern_serializer.sv
`default_nettype none
// ============================================================================
// Module   : pattern_serializer
// Purpose  : Debounced-button-triggered serializer. Transmits a switch word
//            MSB first, one bit every TICK_DIV enabled cycles, either once
//            or continuously.
// Ports    : clk         - clock
//            rst         - asynchronous active-high reset
//            ena         - enable; low freezes counters and the FSM
//            btn_start   - raw pushbutton
//            mode_loop   - 0 single pass, 1 continuous repeat
//            pattern     - word to transmit
//            sig_to_test - serial bit (holds between strobes)
//            sig_valid   - one-cycle strobe per new bit
//            busy        - high while shifting
//            done        - one-cycle pulse after a single pass
//            bit_idx     - index of the most recently emitted bit
// Revision : 1.0 - initial release
// ============================================================================
module pattern_serializer
  import pattern_serializer_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     btn_start,
  input  logic                     mode_loop,
  input  logic [WIDTH-1:0]         pattern,
  output logic                     sig_to_test,
  output logic                     sig_valid,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(WIDTH)-1:0] bit_idx
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned PW = cnt_width(TICK_DIV);
  localparam logic [IW-1:0] C_LAST_BIT  = IW'(WIDTH - 1);
  localparam logic [PW-1:0] C_LAST_TICK = PW'(TICK_DIV - 1);

  logic             w_start_pulse;

  ser_state_t       r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [IW-1:0]    r_cnt;
  logic [PW-1:0]    r_presc;
  logic             r_sig_to_test;
  logic             r_sig_valid;
  logic             r_busy;
  logic             r_done;
  logic [IW-1:0]    r_bit_idx;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk         (clk),
    .rst         (rst),
    .i_ena       (ena),
    .i_btn       (btn_start),
    .start_pulse (w_start_pulse)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_shreg       <= '0;
      r_cnt         <= '0;
      r_presc       <= '0;
      r_sig_to_test <= 1'b0;
      r_sig_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_bit_idx     <= '0;
    end else begin
      // Strobes last one cycle and never fire while disabled.
      r_sig_valid <= 1'b0;
      r_done      <= 1'b0;
      if (ena) begin
        unique case (r_state)
          IDLE: begin
            if (w_start_pulse) begin
              r_shreg <= pattern;
              r_cnt   <= '0;
              r_presc <= '0;
              r_state <= SHIFT;
              r_busy  <= 1'b1;
            end
          end
          SHIFT: begin
            if (r_presc == C_LAST_TICK) begin
              r_presc       <= '0;
              r_sig_to_test <= r_shreg[WIDTH-1];
              r_sig_valid   <= 1'b1;
              r_bit_idx     <= r_cnt;
              if (r_cnt == C_LAST_BIT) begin
                // Pattern boundary: the only point where mode_loop matters.
                r_cnt <= '0;
                if (mode_loop) begin
                  r_shreg <= pattern;
                end else begin
                  r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                end
              end else begin
                r_cnt   <= r_cnt + IW'(1);
                r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
              end
            end else begin
              r_presc <= r_presc + PW'(1);
            end
          end
          DONE: begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sig_to_test = r_sig_to_test;
  assign sig_valid   = r_sig_valid;
  assign busy        = r_busy;
  assign done        = r_done;
  assign bit_idx     = r_bit_idx;

endmodule
`default_nettype wire
